vend_dispense_ctrl: RTL and testbench

//   Downstream stage of the 10 Taka vending FSM: takes one transaction (purchase flag + change code)
//   per handshake and physically executes it. Drives the product motor for a fixed time, then ejects

---
 rtl/vend_dispense_ctrl.sv | 145 ++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vend_dispense_ctrl
//  Purpose  : Executes one vend transaction at a time: runs the product motor,
//             pays change as sensor-confirmed 5 Taka coins, flags hopper jams.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES  = 8,
  parameter int EJECT_TIMEOUT = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             txn_valid,
  input  logic             txn_purchase,
  input  logic [1:0]       txn_change,
  output logic             txn_ready,
  input  logic             coin_sensed,
  input  logic             fault_clear,
  output logic             motor_on,
  output logic             coin_eject,
  output logic             done,
  output logic             fault,
  output logic [1:0]       coins_owed,
  output logic [CNT_W-1:0] coins_paid
);

  // One timer serves both the motor run and the coin-sense timeout.
  localparam int TMR_MAX = (MOTOR_CYCLES > EJECT_TIMEOUT) ? MOTOR_CYCLES : EJECT_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] c_motor_last   = TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_timeout_last = TMR_W'(EJECT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VEND      = 3'd1,
    S_EJECT     = 3'd2,
    S_WAIT_COIN = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [1:0]       r_coins_left;
  logic             r_motor_on;
  logic             r_coin_eject;
  logic             r_done;
  logic             r_fault;
  logic [1:0]       r_coins_owed;
  logic [CNT_W-1:0] r_coins_paid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_coins_left <= '0;
      r_motor_on   <= 1'b0;
      r_coin_eject <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_coins_owed <= '0;
      r_coins_paid <= '0;
    end else begin
      r_done       <= 1'b0;
      r_coin_eject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (txn_valid) begin
            r_coins_left <= txn_change;
            r_timer      <= '0;
            if (txn_purchase) begin
              r_state    <= S_VEND;
              r_motor_on <= 1'b1;
            end else if (txn_change != 2'd0) begin
              r_state      <= S_EJECT;
              r_coin_eject <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_VEND: begin
          if (r_timer == c_motor_last) begin
            r_motor_on <= 1'b0;
            r_timer    <= '0;
            if (r_coins_left != 2'd0) begin
              r_state      <= S_EJECT;
              r_coin_eject <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_EJECT: begin
          r_state <= S_WAIT_COIN;
          r_timer <= '0;
        end
        S_WAIT_COIN: begin
          // A sense in the last allowed cycle still counts as a paid coin.
          if (coin_sensed) begin
            r_coins_paid <= r_coins_paid + CNT_W'(1);
            r_coins_left <= r_coins_left - 2'd1;
            if (r_coins_left == 2'd1) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_EJECT;
              r_coin_eject <= 1'b1;
            end
          end else if (r_timer == c_timeout_last) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_coins_owed <= r_coins_left;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_FAULT: begin
          if (fault_clear) begin
            r_state      <= S_IDLE;
            r_fault      <= 1'b0;
            r_coins_owed <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign txn_ready  = (r_state == S_IDLE);
  assign motor_on   = r_motor_on;
  assign coin_eject = r_coin_eject;
  assign done       = r_done;
  assign fault      = r_fault;
  assign coins_owed = r_coins_owed;
  assign coins_paid = r_coins_paid;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_dispense_ctrl
//  Purpose  : Directed self-checking bench for vend_dispense_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       txn_valid;
  logic       txn_purchase;
  logic [1:0] txn_change;
  logic       txn_ready;
  logic       coin_sensed;
  logic       fault_clear;
  logic       motor_on;
  logic       coin_eject;
  logic       done;
  logic       fault;
  logic [1:0] coins_owed;
  logic [7:0] coins_paid;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_paid = 8'd0;

  vend_dispense_ctrl #(
    .MOTOR_CYCLES (8),
    .EJECT_TIMEOUT(16),
    .CNT_W        (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .txn_valid   (txn_valid),
    .txn_purchase(txn_purchase),
    .txn_change  (txn_change),
    .txn_ready   (txn_ready),
    .coin_sensed (coin_sensed),
    .fault_clear (fault_clear),
    .motor_on    (motor_on),
    .coin_eject  (coin_eject),
    .done        (done),
    .fault       (fault),
    .coins_owed  (coins_owed),
    .coins_paid  (coins_paid)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if ({motor_on, coin_eject, done, fault, coins_owed, coins_paid, txn_ready} !== {4'b0000, 2'd0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: motor=%b eject=%b done=%b fault=%b owed=%0d paid=%0d ready=%b, want 0 0 0 0 0 0 1",
               motor_on, coin_eject, done, fault, coins_owed, coins_paid, txn_ready);
    end
    reset = 1'b0;
    exp_paid = 8'd0;
  endtask

  task automatic test_vend_only;
    txn_valid = 1'b1; txn_purchase = 1'b1; txn_change = 2'd0;
    checks++;
    if (txn_ready !== 1'b1) begin
      errors++; $display("FAIL vend_accept_ready: ready=%b, want 1", txn_ready);
    end
    tick;
    txn_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if ({motor_on, done, coin_eject, txn_ready} !== 4'b1000) begin
        errors++;
        $display("FAIL vend_motor cyc%0d: motor=%b done=%b eject=%b ready=%b, want 1 0 0 0",
                 i, motor_on, done, coin_eject, txn_ready);
      end
      tick;
    end
    checks++;
    if ({motor_on, done, coin_eject, txn_ready} !== 4'b0101) begin
      errors++;
      $display("FAIL vend_done: motor=%b done=%b eject=%b ready=%b, want 0 1 0 1",
               motor_on, done, coin_eject, txn_ready);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL vend_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_purchase_change3;
    txn_valid = 1'b1; txn_purchase = 1'b1; txn_change = 2'd3;
    tick;
    txn_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if ({motor_on, coin_eject} !== 2'b10) begin
        errors++; $display("FAIL p3_motor cyc%0d: motor=%b eject=%b, want 1 0", i, motor_on, coin_eject);
      end
      tick;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({coin_eject, motor_on, done} !== 3'b100) begin
        errors++;
        $display("FAIL p3_eject coin%0d: eject=%b motor=%b done=%b, want 1 0 0", k, coin_eject, motor_on, done);
      end
      tick;
      checks++;
      if (coin_eject !== 1'b0) begin
        errors++; $display("FAIL p3_eject_pulse coin%0d: eject=%b, want 0", k, coin_eject);
      end
      tick;
      coin_sensed = 1'b1;
      tick;
      coin_sensed = 1'b0;
      exp_paid = exp_paid + 8'd1;
    end
    checks++;
    if ({done, coin_eject, txn_ready} !== 3'b101 || coins_paid !== exp_paid) begin
      errors++;
      $display("FAIL p3_done: done=%b eject=%b ready=%b paid=%0d, want 1 0 1 paid=%0d",
               done, coin_eject, txn_ready, coins_paid, exp_paid);
    end
    tick;
  endtask

  task automatic test_change_only;
    txn_valid = 1'b1; txn_purchase = 1'b0; txn_change = 2'd1;
    tick;
    txn_valid = 1'b0;
    checks++;
    if ({coin_eject, motor_on} !== 2'b10) begin
      errors++; $display("FAIL c1_eject: eject=%b motor=%b, want 1 0", coin_eject, motor_on);
    end
    coin_sensed = 1'b1;  // arrives during the eject cycle and must be ignored
    tick;
    coin_sensed = 1'b0;
    checks++;
    if ({coin_eject, done} !== 2'b00 || coins_paid !== exp_paid) begin
      errors++;
      $display("FAIL c1_ignore_early_sense: eject=%b done=%b paid=%0d, want 0 0 paid=%0d",
               coin_eject, done, coins_paid, exp_paid);
    end
    tick;
    coin_sensed = 1'b1;
    tick;
    coin_sensed = 1'b0;
    exp_paid = exp_paid + 8'd1;
    checks++;
    if ({done, txn_ready, motor_on} !== 3'b110 || coins_paid !== exp_paid) begin
      errors++;
      $display("FAIL c1_done: done=%b ready=%b motor=%b paid=%0d, want 1 1 0 paid=%0d",
               done, txn_ready, motor_on, coins_paid, exp_paid);
    end
    tick;
  endtask

  task automatic test_fault;
    txn_valid = 1'b1; txn_purchase = 1'b0; txn_change = 2'd2;
    tick;
    txn_valid = 1'b0;
    tick;
    fault_clear = 1'b1;  // not in FAULT: ignored
    tick;
    fault_clear = 1'b0;
    coin_sensed = 1'b1;
    tick;
    coin_sensed = 1'b0;
    exp_paid = exp_paid + 8'd1;
    checks++;
    if ({coin_eject, fault} !== 2'b10) begin
      errors++; $display("FAIL f_second_eject: eject=%b fault=%b, want 1 0", coin_eject, fault);
    end
    tick;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if ({fault, txn_ready, done} !== 3'b000) begin
        errors++; $display("FAIL f_waiting cyc%0d: fault=%b ready=%b done=%b, want 0 0 0", i, fault, txn_ready, done);
      end
      tick;
    end
    checks++;
    if ({fault, txn_ready, done, motor_on} !== 4'b1000 || coins_owed !== 2'd1 || coins_paid !== exp_paid) begin
      errors++;
      $display("FAIL f_enter: fault=%b ready=%b done=%b motor=%b owed=%0d paid=%0d, want 1 0 0 0 owed=1 paid=%0d",
               fault, txn_ready, done, motor_on, coins_owed, coins_paid, exp_paid);
    end
    txn_valid = 1'b1; txn_purchase = 1'b1; coin_sensed = 1'b1;
    tick;
    tick;
    txn_valid = 1'b0; coin_sensed = 1'b0;
    checks++;
    if ({fault, txn_ready, motor_on} !== 3'b100 || coins_owed !== 2'd1 || coins_paid !== exp_paid) begin
      errors++;
      $display("FAIL f_sticky: fault=%b ready=%b motor=%b owed=%0d paid=%0d, want 1 0 0 owed=1 paid=%0d",
               fault, txn_ready, motor_on, coins_owed, coins_paid, exp_paid);
    end
    fault_clear = 1'b1;
    tick;
    fault_clear = 1'b0;
    checks++;
    if ({fault, done, txn_ready} !== 3'b001 || coins_owed !== 2'd0) begin
      errors++;
      $display("FAIL f_clear: fault=%b done=%b ready=%b owed=%0d, want 0 0 1 owed=0",
               fault, done, txn_ready, coins_owed);
    end
    tick;
  endtask

  task automatic test_sense_beats_timeout;
    txn_valid = 1'b1; txn_purchase = 1'b0; txn_change = 2'd1;
    tick;
    txn_valid = 1'b0;
    tick;
    repeat (15) tick;
    coin_sensed = 1'b1;  // 16th waiting cycle
    tick;
    coin_sensed = 1'b0;
    exp_paid = exp_paid + 8'd1;
    checks++;
    if ({done, fault, txn_ready} !== 3'b101 || coins_paid !== exp_paid) begin
      errors++;
      $display("FAIL last_cycle_sense: done=%b fault=%b ready=%b paid=%0d, want 1 0 1 paid=%0d",
               done, fault, txn_ready, coins_paid, exp_paid);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    txn_valid = 1'b1; txn_purchase = 1'b0; txn_change = 2'd0;
    tick;
    checks++;
    if ({done, txn_ready, coin_eject, motor_on} !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_zero_done: done=%b ready=%b eject=%b motor=%b, want 1 1 0 0",
               done, txn_ready, coin_eject, motor_on);
    end
    txn_change = 2'd1;
    tick;
    txn_valid = 1'b0;
    checks++;
    if ({coin_eject, done, txn_ready} !== 3'b100) begin
      errors++; $display("FAIL b2b_second_eject: eject=%b done=%b ready=%b, want 1 0 0", coin_eject, done, txn_ready);
    end
    tick;
    coin_sensed = 1'b1;
    tick;
    coin_sensed = 1'b0;
    exp_paid = exp_paid + 8'd1;
    checks++;
    if (done !== 1'b1 || coins_paid !== exp_paid) begin
      errors++; $display("FAIL b2b_done: done=%b paid=%0d, want 1 paid=%0d", done, coins_paid, exp_paid);
    end
    tick;
  endtask

  task automatic test_reset_midvend;
    coin_sensed = 1'b1;
    tick;
    tick;
    coin_sensed = 1'b0;
    checks++;
    if (coins_paid !== exp_paid || done !== 1'b0 || coin_eject !== 1'b0) begin
      errors++;
      $display("FAIL idle_spurious_sense: paid=%0d done=%b eject=%b, want paid=%0d 0 0",
               coins_paid, done, coin_eject, exp_paid);
    end
    txn_valid = 1'b1; txn_purchase = 1'b1; txn_change = 2'd3;
    tick;
    txn_valid = 1'b0;
    tick;
    tick;
    checks++;
    if (motor_on !== 1'b1) begin
      errors++; $display("FAIL midvend_motor: motor=%b, want 1", motor_on);
    end
    reset = 1'b1;
    tick;
    exp_paid = 8'd0;
    checks++;
    if ({motor_on, coin_eject, done, fault, txn_ready} !== 5'b00001 || coins_owed !== 2'd0 || coins_paid !== exp_paid) begin
      errors++;
      $display("FAIL midvend_reset: motor=%b eject=%b done=%b fault=%b ready=%b owed=%0d paid=%0d, want 0 0 0 0 1 0 0",
               motor_on, coin_eject, done, fault, txn_ready, coins_owed, coins_paid);
    end
    reset = 1'b0;
    repeat (10) tick;
    checks++;
    if ({motor_on, coin_eject, done} !== 3'b000) begin
      errors++; $display("FAIL midvend_dropped: motor=%b eject=%b done=%b, want 0 0 0", motor_on, coin_eject, done);
    end
  endtask

  initial begin
    reset = 1'b1; txn_valid = 1'b0; txn_purchase = 1'b0; txn_change = 2'd0;
    coin_sensed = 1'b0; fault_clear = 1'b0;
    test_reset;
    test_vend_only;
    test_purchase_change3;
    test_change_only;
    test_fault;
    test_sense_beats_timeout;
    test_back_to_back;
    test_reset_midvend;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
